// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered status flags and error pulses.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word-fall-through read data.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    write_en,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CNT_W-1:0]      count_nxt;

  // Acceptance uses the registered flags, so a full FIFO never takes a write
  // and an empty FIFO never gives a read, even with the opposite access.
  always_comb begin
    wr_acc    = write_en & ~fifo_full;
    rd_acc    = read_en & ~fifo_empty;
    count_nxt = fifo_count;
    if (wr_acc && !rd_acc) begin
      count_nxt = fifo_count + CNT_W'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = fifo_count - CNT_W'(1);
    end
  end

  // Pointers, count and flags; flags are decoded from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count   <= count_nxt;
      fifo_empty   <= (count_nxt == '0);
      fifo_full    <= (count_nxt == FULL_LVL);
      almost_full  <= (count_nxt >= AF_LVL);
      almost_empty <= (count_nxt <= AE_LVL);
      overflow     <= write_en & fifo_full;
      underflow    <= read_en & fifo_empty;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule
